// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a data load/store port onto one
// shared single-port memory. One access is in flight at a time. The flow is
// IDLE -> WAIT -> RESP -> IDLE. A tie between the two requesters is broken
// round-robin. An access that sees no memory acknowledge within TIMEOUT WAIT
// cycles is aborted. It then completes with zero data and sets a sticky err flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request and byte address
//   if_rdata, if_ack         fetch data (zero unless acked), one-cycle ack
//   d_req, d_wren, d_addr,   data request: store/load select, byte address,
//   d_wdata, d_be            store data and byte enables
//   d_rdata, d_ack           load data (zero unless acked, zero for stores), ack
//   m_req, m_wren, m_addr,   shared memory request bundle, driven only in WAIT
//   m_wdata, m_be
//   m_rdata, m_ack           memory read data and completion pulse
//   busy                     high whenever the arbiter is not in IDLE
//   err                      sticky timeout flag, cleared only by rst
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        d_req,
    input  logic        d_wren,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,

    output logic        m_req,
    output logic        m_wren,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,

    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // The counter holds the number of WAIT cycles already spent without an ack.
    // Its last legal value ends the access.
    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    state_t      state;
    logic        gnt_d;      // current access belongs to the data port
    logic        last_d;     // most recent grant went to the data port
    logic [4:0]  cnt;

    logic        grant_d;
    logic        timed_out;
    logic        wait_done;
    logic [31:0] resp_data;

    always_comb begin
        // Data wins when it is alone, or when both ports request and fetch had the last grant.
        grant_d   = d_req && (!if_req || !last_d);
        timed_out = !m_ack && (cnt == CNT_LAST);
        wait_done = m_ack || timed_out;
        // A store ack and an aborted access both return zero.
        resp_data = '0;
        if (m_ack && !(gnt_d && m_wren)) begin
            resp_data = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_d    <= 1'b0;
            last_d   <= 1'b0;
            cnt      <= '0;
            m_req    <= 1'b0;
            m_wren   <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            if_ack   <= 1'b0;
            if_rdata <= '0;
            d_ack    <= 1'b0;
            d_rdata  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        // The m_* registers double as the latched request, so the
                        // bundle holds steady however the requester behaves later.
                        gnt_d  <= grant_d;
                        last_d <= grant_d;
                        cnt    <= '0;
                        m_req  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= WAIT;
                        if (grant_d) begin
                            m_wren  <= d_wren;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end else begin
                            m_wren  <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            m_be    <= '1;
                        end
                    end
                end

                WAIT: begin
                    if (wait_done) begin
                        m_req   <= 1'b0;
                        m_wren  <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        m_be    <= '0;
                        state   <= RESP;
                        if (timed_out) begin
                            err <= 1'b1;
                        end
                        if (gnt_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= resp_data;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= resp_data;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                RESP: begin
                    if_ack   <= 1'b0;
                    if_rdata <= '0;
                    d_ack    <= 1'b0;
                    d_rdata  <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed and random checks of mem_arbiter, built with TIMEOUT=4.
// The memory responder acknowledges in the Nth cycle that m_req is high, where N is mem_lat.
// A mem_lat of 0 means the responder never acknowledges.
// The expected timeline of each run is worked out per access with plain
// arithmetic: the grant cycle, the number of WAIT cycles and the RESP cycle.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_wren;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_wren;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_wren(m_wren), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_rdata(m_rdata), .m_ack(m_ack),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // The memory contents are a fixed function of the address.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h3C01_1234;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder. It updates 2 time units after each rising edge.
    int mem_lat = 1;
    bit stray_ack = 1'b0;
    int mcnt = 0;
    always @(posedge clk) begin
        #2;
        if (m_req) mcnt++;
        else mcnt = 0;
        m_ack   = stray_ack || (m_req && mem_lat != 0 && mcnt == mem_lat);
        m_rdata = m_ack ? rdata_of(m_addr) : $urandom();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          last_d_m;   // round-robin memory: last grant was data
    bit          err_m;      // sticky error from earlier runs
    logic [31:0] i_addr_v;
    logic [31:0] d_addr_v;
    logic [31:0] d_wdata_v;
    logic [3:0]  d_be_v;
    bit          d_wren_v;

    // Accesses of the current run, listed in grant order
    int n_ent = 0;
    bit e_d[4];
    int e_start[4];
    int e_w[4];
    bit e_to[4];

    task automatic add_entry(input bit is_d, input int lat);
        int k;
        k = n_ent;
        e_d[k]     = is_d;
        e_start[k] = (k == 0) ? 0 : e_start[k-1] + e_w[k-1] + 2;
        e_to[k]    = !(lat >= 1 && lat <= int'(TO));
        e_w[k]     = e_to[k] ? int'(TO) : lat;
        last_d_m   = is_d;
        n_ent++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":m_req"},    32'(m_req),  '0);
        chk({tag, ":m_wren"},   32'(m_wren), '0);
        chk({tag, ":m_be"},     32'(m_be),   '0);
        chk({tag, ":m_addr"},   m_addr,      '0);
        chk({tag, ":m_wdata"},  m_wdata,     '0);
        chk({tag, ":if_ack"},   32'(if_ack), '0);
        chk({tag, ":d_ack"},    32'(d_ack),  '0);
        chk({tag, ":if_rdata"}, if_rdata,    '0);
        chk({tag, ":d_rdata"},  d_rdata,     '0);
        chk({tag, ":busy"},     32'(busy),   '0);
        chk({tag, ":err"},      32'(err),    '0);
    endtask

    task automatic check_cycle(input string tag, input int t);
        logic        x_mreq, x_busy, x_iack, x_dack, x_err, x_wren;
        logic [31:0] x_ird, x_drd, x_addr, x_wdata, data;
        logic [3:0]  x_be;
        x_mreq = 0; x_busy = 0; x_iack = 0; x_dack = 0; x_err = err_m;
        x_ird = '0; x_drd = '0; x_addr = '0; x_wdata = '0; x_be = '0; x_wren = 0;
        for (int k = 0; k < n_ent; k++) begin
            int ws, we, rc;
            ws = e_start[k] + 1;
            we = e_start[k] + e_w[k];
            rc = we + 1;
            if (t >= ws && t <= we) begin
                x_mreq = 1; x_busy = 1;
                if (e_d[k]) begin
                    x_addr = d_addr_v; x_wren = d_wren_v; x_be = d_be_v; x_wdata = d_wdata_v;
                end else begin
                    x_addr = i_addr_v; x_wren = 0; x_be = 4'hF;
                end
            end
            if (t == rc) begin
                x_busy = 1;
                if (e_to[k]) data = '0;
                else if (e_d[k]) data = d_wren_v ? 32'h0 : rdata_of(d_addr_v);
                else data = rdata_of(i_addr_v);
                if (e_d[k]) begin x_dack = 1; x_drd = data; end
                else begin x_iack = 1; x_ird = data; end
            end
            if (e_to[k] && t >= rc) x_err = 1;
        end
        chk($sformatf("%s:m_req@%0d", tag, t),    32'(m_req),  32'(x_mreq));
        chk($sformatf("%s:busy@%0d", tag, t),     32'(busy),   32'(x_busy));
        chk($sformatf("%s:if_ack@%0d", tag, t),   32'(if_ack), 32'(x_iack));
        chk($sformatf("%s:d_ack@%0d", tag, t),    32'(d_ack),  32'(x_dack));
        chk($sformatf("%s:if_rdata@%0d", tag, t), if_rdata,    x_ird);
        chk($sformatf("%s:d_rdata@%0d", tag, t),  d_rdata,     x_drd);
        chk($sformatf("%s:err@%0d", tag, t),      32'(err),    32'(x_err));
        if (x_mreq) begin
            chk($sformatf("%s:m_addr@%0d", tag, t), m_addr,      x_addr);
            chk($sformatf("%s:m_wren@%0d", tag, t), 32'(m_wren), 32'(x_wren));
            chk($sformatf("%s:m_be@%0d", tag, t),   32'(m_be),   32'(x_be));
            if (x_wren) chk($sformatf("%s:m_wdata@%0d", tag, t), m_wdata, x_wdata);
        end
    endtask

    // Runs the accesses listed so far. Cycle 0 is the current cycle, in which the requests are raised.
    task automatic run_entries(input string tag, input int lat);
        int end_c;
        bit any_to;
        mem_lat = lat;
        any_to  = 0;
        for (int k = 0; k < n_ent; k++) begin
            if (e_d[k]) d_req = 1'b1;
            else if_req = 1'b1;
            if (e_to[k]) any_to = 1;
        end
        if_addr = i_addr_v;
        d_addr  = d_addr_v; d_wren = d_wren_v; d_wdata = d_wdata_v; d_be = d_be_v;
        end_c = e_start[n_ent-1] + e_w[n_ent-1] + 1;
        check_cycle(tag, 0);
        for (int t = 1; t <= end_c + 1; t++) begin
            tick();
            check_cycle(tag, t);
            // A requester drops its request after its ack unless another access is queued for it.
            for (int k = 0; k < n_ent; k++) begin
                if (t == e_start[k] + e_w[k] + 1) begin
                    bit more;
                    more = 0;
                    for (int j = k + 1; j < n_ent; j++) if (e_d[j] == e_d[k]) more = 1;
                    if (!more) begin
                        if (e_d[k]) d_req = 1'b0;
                        else if_req = 1'b0;
                    end
                end
            end
        end
        if (any_to) err_m = 1;
        n_ent = 0;
    endtask

    task automatic do_reset(input bit hold_i, input bit hold_d);
        rst = 1'b1; if_req = hold_i; d_req = hold_d;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        last_d_m = 0;
        err_m = 0;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; d_req = 0; if_addr = '0;
        d_wren = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; d_be_v = '0; d_wren_v = 0;
        last_d_m = 0; err_m = 0;

        do_reset(0, 0);

        // Fetch of 0x40. The memory acks in the second WAIT cycle.
        i_addr_v = 32'h0000_0040;
        add_entry(0, 2);
        run_entries("fetch40", 2);

        // Store with the ack in the first WAIT cycle. d_ack comes in cycle 2.
        d_addr_v = 32'h10; d_wdata_v = 32'hCAFE_F00D; d_be_v = 4'b0011; d_wren_v = 1;
        add_entry(1, 1);
        run_entries("store10", 1);

        // Both ports request from reset. Expected grant order: D,I,D,I.
        i_addr_v = 32'h0000_0100; d_addr_v = 32'h0000_0200; d_wren_v = 0; d_be_v = 4'hF;
        if_addr = i_addr_v; d_addr = d_addr_v; d_wren = 0; d_be = d_be_v;
        do_reset(1, 1);
        add_entry(1, 1); add_entry(0, 1); add_entry(1, 1); add_entry(0, 1);
        run_entries("rr", 1);

        // Timeout on a load, then a normal fetch. err stays set.
        d_addr_v = 32'h0000_0300; d_wren_v = 0;
        add_entry(1, 0);
        run_entries("timeout", 0);
        i_addr_v = 32'h0000_0044;
        add_entry(0, 3);
        run_entries("after_to", 3);

        // Reset in the second WAIT cycle, followed by a stray m_ack.
        do_reset(0, 0);
        mem_lat = 3;
        d_addr = 32'h0000_0080; d_wren = 0; d_be = 4'hF; d_req = 1'b1;
        tick();
        chk("abort:m_req_w1", 32'(m_req), 32'd1);
        tick();
        chk("abort:m_req_w2", 32'(m_req), 32'd1);
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0; stray_ack = 1'b1;
        chk_zero("abort_c3");
        tick();
        stray_ack = 1'b0;
        chk_zero("abort_c4");
        tick();
        chk_zero("abort_c5");
        last_d_m = 0; err_m = 0;
        d_addr_v = 32'h0000_0084; d_wren_v = 0; d_be_v = 4'hF;
        add_entry(1, 1);
        run_entries("post_abort", 1);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            int sel, lat;
            bit first;
            sel = int'($urandom_range(1, 3));
            lat = int'($urandom_range(0, 6));
            i_addr_v  = $urandom() & 32'hFFFF_FFFC;
            d_addr_v  = $urandom();
            d_wdata_v = $urandom();
            d_be_v    = 4'($urandom());
            d_wren_v  = 1'($urandom());
            if (sel == 3) begin
                first = !last_d_m;
                add_entry(first, lat);
                add_entry(!first, lat);
            end else begin
                add_entry(sel == 2, lat);
            end
            run_entries("rand", lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
